next_block_queue: RTL and testbench
===================================

NEXT_BLOCK_QUEUE -- requirements
Module: next_block_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of queued blocks (minimum 2).
REQ-002 SHALL have parameter GEN_LATENCY, default 3, clock edges from a generator enable pulse until the generator outputs are stable.
REQ-003 SHALL have parameter REROLL_EN, default 1, which enables a single re-request when a captured color equals the previous one.
REQ-004 SHALL have one clock and asynchronous active-low reset; ports listed below.
REQ-005 clk_i  in  1  sole clock; all logic on rising edge.
REQ-006 rst_n_i  in  1  asynchronous, active-low reset.
REQ-007 gen_en_o  out  1  enable pulse to the next-block generator; one cycle per request.
REQ-008 gen_data_i  in  64  four 4x4 rotation bitmaps from the generator.
REQ-009 gen_color_i  in  TETRIS_COLORS_WIDTH  block color (0 is background and never valid).
REQ-010 gen_rotation_i  in  2  initial rotation.
REQ-011 gen_x_i / gen_y_i  in  signed FIELD_COL_CNT_WIDTH+1 / FIELD_ROW_CNT_WIDTH+1  spawn position.
REQ-012 flush_i  in  1  synchronous queue clear (game restart).
REQ-013 blk_valid_o  out  1  head entry is available.
REQ-014 blk_ready_i  in  1  game FSM accepts the head entry.
REQ-015 blk_data_o, blk_color_o, blk_rotation_o, blk_x_o, blk_y_o  out  same widths as gen_*  head entry fields.
REQ-016 preview_valid_o  out  1  entry 1 is present.
REQ-017 preview_data_o, preview_color_o  out  64 / TETRIS_COLORS_WIDTH  entry 1 fields, for the "next piece" display.

Function
REQ-018 Refill FSM states SHALL be IDLE, PULSE, WAIT and CAPTURE.
REQ-019 IDLE->PULSE SHALL occur when the number of entries plus in-flight requests is less than DEPTH; otherwise the FSM stays in IDLE.
REQ-020 In PULSE, gen_en_o SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT.
REQ-021 WAIT SHALL count GEN_LATENCY-1 cycles, then go to CAPTURE; the sample taken in CAPTURE SHALL reflect the generator state GEN_LATENCY edges after the pulse edge.
REQ-022 CAPTURE SHALL push the gen_* fields to the tail, record last_color and go to IDLE.
REQ-023 Exception: if REROLL_EN=1, the color equals last_color and no reroll has been used for this slot, CAPTURE SHALL discard the sample and go to PULSE; the second sample SHALL always be pushed.
REQ-024 Pop SHALL occur on blk_valid_o && blk_ready_i; entries SHALL shift so entry 1 becomes the head the next cycle.
REQ-025 blk_valid_o SHALL be 1 iff count >= 1; preview_valid_o SHALL be 1 iff count >= 2.
REQ-026 Head and preview outputs SHALL be registered, and invalid fields SHALL read 0.
REQ-027 Push and pop in the same cycle SHALL leave count unchanged, with the new entry at the correct position.
REQ-028 A push to a full queue SHALL be structurally impossible; an assertion SHALL flag it.
REQ-029 blk_ready_i while blk_valid_o=0 SHALL be ignored.
REQ-030 flush_i SHALL set count to 0 and the FSM to IDLE, abort any in-flight request (no late push) and clear last_color; it SHALL override a simultaneous pop or capture.
REQ-031 After reset or flush, the queue SHALL reach DEPTH entries with no pops within DEPTH*(GEN_LATENCY+2) cycles, plus GEN_LATENCY+1 cycles per reroll.

Reset
REQ-032 While rst_n_i=0, count=0, the FSM SHALL be in IDLE, and gen_en_o, all blk_*/preview_* outputs, last_color and the WAIT counter SHALL be 0.
REQ-033 Reset assertion mid-request SHALL drop that request; refill SHALL start in the first cycle after deassertion.

Structure
REQ-034 A shared tetris package SHALL hold block_info_t (data, color, rotation, x, y) and the GEN_LATENCY default; defs.vh widths SHALL be reused.
REQ-035 Storage SHALL be one sub-module, block_info_shiftq (DEPTH x block_info_t shift queue with push, pop and flush), with the FSM kept in next_block_queue.

Verification
REQ-036 Reset release with the generator model (PRBS seeded to 1), DEPTH=2 and no pops -> gen_en_o pulses twice; blk_valid_o=1 and preview_valid_o=1 by cycle 10; no further pulses.
REQ-037 Pop with blk_ready_i=1 for 1 cycle -> next cycle the former preview is the head and preview_valid_o=0; one gen_en_o pulse follows and preview_valid_o=1 after GEN_LATENCY+2 cycles.
REQ-038 Forced generator colors 3,3,5 -> queue holds 3 then 5 (one reroll); forced 4,4,4 -> queue holds 4,4 (reroll used only once).
REQ-039 Push and pop in the same cycle with count=1 -> count stays 1 and the head equals the newly captured entry.
REQ-040 flush_i asserted during WAIT -> next cycle count=0; no push from the aborted request; refill restarts and fills within 10 cycles.
REQ-041 rst_n_i low for 1 cycle during WAIT -> outputs 0 immediately (asynchronous); refill resumes after release.

Source files
------------

// File: rtl/next_block_queue_pkg.sv
// -----------------------------------------------------------------------------
// next_block_queue_pkg
// Shared tetris definitions used by the next-block queue and its storage:
//   - playfield / color widths, shared with the rest of the game
//   - block_info_t : one queued piece (bitmaps, color, rotation, spawn x/y)
//   - refill_state_t : refill FSM encoding
//   - GEN_LATENCY_DEFAULT : default generator latency
// -----------------------------------------------------------------------------
package next_block_queue_pkg;

    // Widths shared with the game's global definitions.
    localparam int TETRIS_COLORS_WIDTH = 3;
    localparam int FIELD_COL_CNT_WIDTH = 4;
    localparam int FIELD_ROW_CNT_WIDTH = 5;

    localparam int BLK_X_WIDTH = FIELD_COL_CNT_WIDTH + 1;
    localparam int BLK_Y_WIDTH = FIELD_ROW_CNT_WIDTH + 1;

    // Clock edges from the generator enable pulse until its outputs settle.
    localparam int GEN_LATENCY_DEFAULT = 3;

    typedef struct packed {
        logic [63:0]                     data;     // four 4x4 rotation bitmaps
        logic [TETRIS_COLORS_WIDTH-1:0]  color;    // 0 = background, never valid
        logic [1:0]                      rotation;
        logic signed [BLK_X_WIDTH-1:0]   x;
        logic signed [BLK_Y_WIDTH-1:0]   y;
    } block_info_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } refill_state_t;

endpackage

// File: rtl/next_block_queue_if.sv
// -----------------------------------------------------------------------------
// next_block_queue_if
// Bundles the generator handshake, the head/preview block outputs and the
// game-side controls of next_block_queue.
//   master : the queue itself (drives gen_en_o, blk_*, preview_*)
//   slave  : the environment (generator + game FSM)
// -----------------------------------------------------------------------------
interface next_block_queue_if;
    import next_block_queue_pkg::*;

    // Generator side
    logic                            gen_en_o;
    logic [63:0]                     gen_data_i;
    logic [TETRIS_COLORS_WIDTH-1:0]  gen_color_i;
    logic [1:0]                      gen_rotation_i;
    logic signed [BLK_X_WIDTH-1:0]   gen_x_i;
    logic signed [BLK_Y_WIDTH-1:0]   gen_y_i;

    // Game side
    logic                            flush_i;
    logic                            blk_valid_o;
    logic                            blk_ready_i;
    logic [63:0]                     blk_data_o;
    logic [TETRIS_COLORS_WIDTH-1:0]  blk_color_o;
    logic [1:0]                      blk_rotation_o;
    logic signed [BLK_X_WIDTH-1:0]   blk_x_o;
    logic signed [BLK_Y_WIDTH-1:0]   blk_y_o;
    logic                            preview_valid_o;
    logic [63:0]                     preview_data_o;
    logic [TETRIS_COLORS_WIDTH-1:0]  preview_color_o;

    modport master (
        output gen_en_o,
        input  gen_data_i, gen_color_i, gen_rotation_i, gen_x_i, gen_y_i,
        input  flush_i, blk_ready_i,
        output blk_valid_o, blk_data_o, blk_color_o, blk_rotation_o,
        output blk_x_o, blk_y_o,
        output preview_valid_o, preview_data_o, preview_color_o
    );

    modport slave (
        input  gen_en_o,
        output gen_data_i, gen_color_i, gen_rotation_i, gen_x_i, gen_y_i,
        output flush_i, blk_ready_i,
        input  blk_valid_o, blk_data_o, blk_color_o, blk_rotation_o,
        input  blk_x_o, blk_y_o,
        input  preview_valid_o, preview_data_o, preview_color_o
    );

endinterface

// File: rtl/block_info_shiftq.sv
// -----------------------------------------------------------------------------
// block_info_shiftq
// DEPTH-entry shift queue of block_info_t. Entry 0 is the head, entry 1 the
// preview. A pop shifts every entry down by one; a push writes at the first
// free slot (accounting for a simultaneous pop). Unused slots are held at 0 so
// the head/preview outputs read 0 whenever they are not valid.
// Ports:
//   clk_i, rst_n_i            clock, asynchronous active-low reset
//   push_i, push_data_i       write one entry at the tail
//   pop_i                     drop the head (ignored when empty)
//   flush_i                   clear the queue; overrides push and pop
//   count_o                   number of valid entries
//   head_o / head_valid_o     entry 0 (registered)
//   preview_o / preview_valid_o entry 1 (registered)
// -----------------------------------------------------------------------------
module block_info_shiftq
    import next_block_queue_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              push_i,
    input  block_info_t       push_data_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic [CNT_W-1:0]  count_o,
    output block_info_t       head_o,
    output logic              head_valid_o,
    output block_info_t       preview_o,
    output logic              preview_valid_o
);

    block_info_t      entry_q [DEPTH];
    block_info_t      entry_d [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] wr_idx;
    logic             pop_eff;
    logic             head_valid_q;
    logic             preview_valid_q;

    // A pop request against an empty queue is dropped.
    assign pop_eff = pop_i && (count_q != '0);
    // With a concurrent pop the tail moves down one slot before the write.
    assign wr_idx  = count_q - CNT_W'(pop_eff);

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_eff);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            block_info_t shifted;
            if (gi == DEPTH - 1) begin : g_top
                assign shifted = pop_eff ? '0 : entry_q[gi];
            end else begin : g_mid
                assign shifted = pop_eff ? entry_q[gi+1] : entry_q[gi];
            end
            assign entry_d[gi] = flush_i                               ? '0          :
                                 (push_i && (wr_idx == CNT_W'(gi)))    ? push_data_i :
                                                                         shifted;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            count_q         <= '0;
            head_valid_q    <= 1'b0;
            preview_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
            count_q         <= count_d;
            head_valid_q    <= (count_d != '0);
            preview_valid_q <= (count_d >= CNT_W'(2));
        end
    end

    assign count_o         = count_q;
    assign head_o          = entry_q[0];
    assign head_valid_o    = head_valid_q;
    assign preview_o       = entry_q[1];
    assign preview_valid_o = preview_valid_q;

    // The refill FSM never requests while the queue is full.
    a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(push_i && !flush_i && !pop_eff && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/next_block_queue.sv
// -----------------------------------------------------------------------------
// next_block_queue
// Keeps DEPTH upcoming tetris pieces ready for the game FSM. A refill FSM
// requests a new piece from the generator (one-cycle gen_en_o pulse), waits
// GEN_LATENCY edges for it to settle, then captures it into the storage queue.
// With REROLL_EN a piece whose color repeats the previous one is requested
// once more; the second sample is always taken.
// Ports:
//   clk_i    clock (rising edge)
//   rst_n_i  asynchronous active-low reset
//   bus      next_block_queue_if.master: generator handshake, head/preview
//            block outputs, blk_ready_i pop handshake, flush_i
// -----------------------------------------------------------------------------
module next_block_queue
    import next_block_queue_pkg::*;
#(
    parameter  int DEPTH       = 2,
    parameter  int GEN_LATENCY = GEN_LATENCY_DEFAULT,
    parameter  int REROLL_EN   = 1,
    localparam int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    next_block_queue_if.master  bus
);

    localparam int WAIT_CW   = $clog2(GEN_LATENCY + 1);
    localparam int WAIT_LAST = (GEN_LATENCY > 1) ? GEN_LATENCY - 2 : 0;

    refill_state_t                  state_q;
    logic                           gen_en_q;
    logic [WAIT_CW-1:0]             wait_cnt_q;
    logic [TETRIS_COLORS_WIDTH-1:0] last_color_q;
    logic                           rerolled_q;

    block_info_t      sample;
    block_info_t      head;
    block_info_t      preview;
    logic             head_valid;
    logic             preview_valid;
    logic [CNT_W-1:0] count;
    logic             reroll_hit;
    logic             capture_push;
    logic             pop;

    assign sample = '{data:     bus.gen_data_i,
                      color:    bus.gen_color_i,
                      rotation: bus.gen_rotation_i,
                      x:        bus.gen_x_i,
                      y:        bus.gen_y_i};

    // One re-request per slot; rerolled_q is cleared once the slot is filled.
    assign reroll_hit   = (REROLL_EN != 0) && (sample.color == last_color_q) && !rerolled_q;
    assign capture_push = (state_q == ST_CAPTURE) && !reroll_hit && !bus.flush_i;
    assign pop          = bus.blk_ready_i && head_valid;

    // Refill FSM. It handles a single request at a time, so in IDLE there is
    // never a request in flight and the occupancy check reduces to count.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            gen_en_q     <= 1'b0;
            wait_cnt_q   <= '0;
            last_color_q <= '0;
            rerolled_q   <= 1'b0;
        end else if (bus.flush_i) begin
            // Abandon any outstanding request; its late result is never sampled.
            state_q      <= ST_IDLE;
            gen_en_q     <= 1'b0;
            wait_cnt_q   <= '0;
            last_color_q <= '0;
            rerolled_q   <= 1'b0;
        end else begin
            gen_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (count < CNT_W'(DEPTH)) begin
                        state_q  <= ST_PULSE;
                        gen_en_q <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    wait_cnt_q <= '0;
                    state_q    <= (GEN_LATENCY > 1) ? ST_WAIT : ST_CAPTURE;
                end
                ST_WAIT: begin
                    if (wait_cnt_q == WAIT_CW'(WAIT_LAST)) begin
                        wait_cnt_q <= '0;
                        state_q    <= ST_CAPTURE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (reroll_hit) begin
                        rerolled_q <= 1'b1;
                        state_q    <= ST_PULSE;
                        gen_en_q   <= 1'b1;
                    end else begin
                        last_color_q <= sample.color;
                        rerolled_q   <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    block_info_shiftq #(
        .DEPTH (DEPTH)
    ) u_shiftq (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .push_i          (capture_push),
        .push_data_i     (sample),
        .pop_i           (pop),
        .flush_i         (bus.flush_i),
        .count_o         (count),
        .head_o          (head),
        .head_valid_o    (head_valid),
        .preview_o       (preview),
        .preview_valid_o (preview_valid)
    );

    assign bus.gen_en_o        = gen_en_q;
    assign bus.blk_valid_o     = head_valid;
    assign bus.blk_data_o      = head.data;
    assign bus.blk_color_o     = head.color;
    assign bus.blk_rotation_o  = head.rotation;
    assign bus.blk_x_o         = head.x;
    assign bus.blk_y_o         = head.y;
    assign bus.preview_valid_o = preview_valid;
    assign bus.preview_data_o  = preview.data;
    assign bus.preview_color_o = preview.color;

endmodule

// File: tb/tb_next_block_queue.sv
// -----------------------------------------------------------------------------
// tb_next_block_queue
// Directed bench for next_block_queue (DEPTH=2, GEN_LATENCY=3, REROLL_EN=1).
// A generator model answers each gen_en_o pulse GEN_LATENCY edges later with a
// color taken from a per-scenario table and bitmaps from a 16-bit PRBS seeded
// to 1 (first outputs 0001, 0002, 0004, ... replicated four times).
// -----------------------------------------------------------------------------
module tb_next_block_queue;
    import next_block_queue_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_vec  = 0;
    int n_miss = 0;
    int pulse_cnt = 0;

    logic [TETRIS_COLORS_WIDTH-1:0] color_tab [16];

    next_block_queue_if bus();

    next_block_queue #(
        .DEPTH       (2),
        .GEN_LATENCY (3),
        .REROLL_EN   (1)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Generator model: result appears at the 3rd edge after the pulse is raised.
    logic        en_d1, en_d2;
    logic [15:0] prbs_q;
    logic [3:0]  gen_idx;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_d1              <= 1'b0;
            en_d2              <= 1'b0;
            prbs_q             <= 16'h0001;
            gen_idx            <= 4'd0;
            bus.gen_data_i     <= '0;
            bus.gen_color_i    <= '0;
            bus.gen_rotation_i <= '0;
            bus.gen_x_i        <= '0;
            bus.gen_y_i        <= '0;
        end else begin
            en_d1 <= bus.gen_en_o;
            en_d2 <= en_d1;
            if (en_d2) begin
                bus.gen_data_i     <= {4{prbs_q}};
                bus.gen_color_i    <= color_tab[gen_idx];
                bus.gen_rotation_i <= gen_idx[1:0];
                bus.gen_x_i        <= $signed({1'b0, gen_idx});
                bus.gen_y_i        <= $signed({2'b00, gen_idx});
                prbs_q  <= {prbs_q[14:0], prbs_q[15] ^ prbs_q[13] ^ prbs_q[12] ^ prbs_q[10]};
                gen_idx <= gen_idx + 4'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.gen_en_o === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Advance to the next negedge at which gen_en_o is high (bounded).
    task automatic wait_pulse(input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (bus.gen_en_o !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_val(tag, 64'(bus.gen_en_o), 64'd1);
    endtask

    // Negedges until preview_valid_o rises (bounded).
    task automatic count_until_preview(output int cyc);
        cyc = 0;
        while (bus.preview_valid_o !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    int cyc;
    int base;

    initial begin
        bus.flush_i     = 1'b0;
        bus.blk_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) color_tab[i] = 3'd1;

        // ---- Reset state, fill after release, preview timing ----
        color_tab[0] = 3'd2; color_tab[1] = 3'd6; color_tab[2] = 3'd4;
        repeat (3) @(negedge clk);
        check_val("rst_blk_valid",  64'(bus.blk_valid_o),     64'd0);
        check_val("rst_prev_valid", 64'(bus.preview_valid_o), 64'd0);
        check_val("rst_gen_en",     64'(bus.gen_en_o),        64'd0);
        check_val("rst_blk_data",   bus.blk_data_o,           64'd0);
        check_val("rst_blk_color",  64'(bus.blk_color_o),     64'd0);
        base  = pulse_cnt;
        rst_n = 1'b1;
        count_until_preview(cyc);
        check_val("fill_cycles",    64'(cyc),                 64'd10);
        check_val("fill_pulses",    64'(pulse_cnt - base),    64'd2);
        check_val("fill_head_col",  64'(bus.blk_color_o),     64'd2);
        check_val("fill_head_data", bus.blk_data_o,           64'h0001_0001_0001_0001);
        check_val("fill_prev_col",  64'(bus.preview_color_o), 64'd6);
        check_val("fill_prev_data", bus.preview_data_o,       64'h0002_0002_0002_0002);
        repeat (10) @(negedge clk);
        check_val("full_no_pulse",  64'(pulse_cnt - base),    64'd2);

        // ---- Single pop: preview moves to head, one refill ----
        bus.blk_ready_i = 1'b1;
        @(negedge clk);
        bus.blk_ready_i = 1'b0;
        check_val("pop_head_col",   64'(bus.blk_color_o),     64'd6);
        check_val("pop_head_data",  bus.blk_data_o,           64'h0002_0002_0002_0002);
        check_val("pop_prev_valid", 64'(bus.preview_valid_o), 64'd0);
        check_val("pop_prev_data",  bus.preview_data_o,       64'd0);
        check_val("pop_prev_col",   64'(bus.preview_color_o), 64'd0);
        base = pulse_cnt;
        count_until_preview(cyc);
        check_val("refill_cycles",  64'(cyc),                 64'd5);
        check_val("refill_pulses",  64'(pulse_cnt - base),    64'd1);
        check_val("refill_prev_col",64'(bus.preview_color_o), 64'd4);
        check_val("refill_prev_dat",bus.preview_data_o,       64'h0004_0004_0004_0004);

        // ---- Reroll: colors 3,3,5 ----
        apply_reset();
        color_tab[0] = 3'd3; color_tab[1] = 3'd3; color_tab[2] = 3'd5;
        base  = pulse_cnt;
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check_val("rr335_pulses",   64'(pulse_cnt - base),    64'd3);
        check_val("rr335_head_col", 64'(bus.blk_color_o),     64'd3);
        check_val("rr335_head_dat", bus.blk_data_o,           64'h0001_0001_0001_0001);
        check_val("rr335_prev_col", 64'(bus.preview_color_o), 64'd5);
        check_val("rr335_prev_dat", bus.preview_data_o,       64'h0004_0004_0004_0004);

        // ---- Reroll used only once: colors 4,4,4 ----
        apply_reset();
        color_tab[0] = 3'd4; color_tab[1] = 3'd4; color_tab[2] = 3'd4;
        base  = pulse_cnt;
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check_val("rr444_pulses",   64'(pulse_cnt - base),    64'd3);
        check_val("rr444_head_col", 64'(bus.blk_color_o),     64'd4);
        check_val("rr444_prev_col", 64'(bus.preview_color_o), 64'd4);
        check_val("rr444_prev_dat", bus.preview_data_o,       64'h0004_0004_0004_0004);

        // ---- Push and pop in the same cycle with count=1 ----
        apply_reset();
        color_tab[0] = 3'd1; color_tab[1] = 3'd2; color_tab[2] = 3'd7;
        rst_n = 1'b1;
        wait_pulse("pp_pulse1");
        wait_pulse("pp_pulse2");
        repeat (3) @(negedge clk);          // now in CAPTURE of the 2nd request
        bus.blk_ready_i = 1'b1;
        @(negedge clk);
        bus.blk_ready_i = 1'b0;
        check_val("pp_blk_valid",   64'(bus.blk_valid_o),     64'd1);
        check_val("pp_prev_valid",  64'(bus.preview_valid_o), 64'd0);
        check_val("pp_head_col",    64'(bus.blk_color_o),     64'd2);
        check_val("pp_head_data",   bus.blk_data_o,           64'h0002_0002_0002_0002);
        check_val("pp_head_rot",    64'(bus.blk_rotation_o),  64'd1);
        check_val("pp_head_x",      64'(bus.blk_x_o),         64'd1);
        check_val("pp_head_y",      64'(bus.blk_y_o),         64'd1);
        count_until_preview(cyc);
        check_val("pp_refill_cyc",  64'(cyc),                 64'd5);
        check_val("pp_prev_col",    64'(bus.preview_color_o), 64'd7);

        // ---- Flush during WAIT, ready while empty is ignored ----
        apply_reset();
        color_tab[0] = 3'd1; color_tab[1] = 3'd2; color_tab[2] = 3'd3;
        rst_n = 1'b1;
        wait_pulse("fl_pulse");
        @(negedge clk);                     // WAIT
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i     = 1'b0;
        bus.blk_ready_i = 1'b1;
        check_val("fl_blk_valid",   64'(bus.blk_valid_o),     64'd0);
        check_val("fl_prev_valid",  64'(bus.preview_valid_o), 64'd0);
        @(negedge clk);
        bus.blk_ready_i = 1'b0;
        count_until_preview(cyc);
        check_val("fl_fill_cycles", 64'(cyc + 1),             64'd10);
        check_val("fl_head_col",    64'(bus.blk_color_o),     64'd2);
        check_val("fl_head_data",   bus.blk_data_o,           64'h0002_0002_0002_0002);
        check_val("fl_prev_col",    64'(bus.preview_color_o), 64'd3);

        // ---- Asynchronous reset pulse during WAIT ----
        apply_reset();
        color_tab[0] = 3'd5; color_tab[1] = 3'd6;
        rst_n = 1'b1;
        wait_pulse("ar_pulse1");
        wait_pulse("ar_pulse2");
        @(negedge clk);                     // WAIT of the 2nd request
        check_val("ar_pre_col",     64'(bus.blk_color_o),     64'd5);
        rst_n = 1'b0;
        #1;
        check_val("ar_blk_valid",   64'(bus.blk_valid_o),     64'd0);
        check_val("ar_blk_color",   64'(bus.blk_color_o),     64'd0);
        check_val("ar_blk_data",    bus.blk_data_o,           64'd0);
        check_val("ar_gen_en",      64'(bus.gen_en_o),        64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_until_preview(cyc);
        check_val("ar_fill_cycles", 64'(cyc),                 64'd10);
        check_val("ar_head_col",    64'(bus.blk_color_o),     64'd5);
        check_val("ar_prev_col",    64'(bus.preview_color_o), 64'd6);
        check_val("ar_prev_data",   bus.preview_data_o,       64'h0002_0002_0002_0002);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
